// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD adder family: FSM states, BCD digit limits
// and a digit-validity helper.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_ADJ = 4'd6;

   function automatic logic is_bcd(input logic [3:0] nibble);
      return (nibble <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Request/result bundle for the digit-serial BCD adder.
// The master drives operands and the start strobe; the slave returns status and result.
interface bcd_serial_adder_if #(
   parameter int NDIG = 4
);
   localparam int W = 4 * NDIG;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         err;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, err
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, err
   );

endinterface

// File: rtl/bcd_digit_add.sv
// Single-digit BCD add cell: binary add, then +6 correction when the raw sum
// exceeds 9. Purely combinational; also used by the parallel adder path.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [4:0] t;

   // raw binary sum (0..19 for valid digits, up to 31 otherwise) and decimal correction
   always_comb begin
      t  = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
      s  = t[3:0];
      co = 1'b0;
      if (t > {1'b0, BCD_MAX}) begin
         s  = t[3:0] + BCD_ADJ;
         co = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial NDIG-digit BCD adder. Operands are latched on an accepted
// start and summed one digit per clock, least significant digit first.
// Result, carry-out and the invalid-digit flag hold until the next accept.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for start; outputs hold the previous result
//  ADD   | one digit per cycle, exactly NDIG cycles
//  DONE  | one cycle, done=1, sum/cout/err valid
module bcd_serial_adder
   import bcd_pkg::*;
#(
   parameter int NDIG = 4
)(
   input  logic              clk,
   input  logic              rst,
   bcd_serial_adder_if.slave bus
);

   localparam int W  = 4 * NDIG;
   localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

   state_t        state_q;
   state_t        state_d;
   logic          accept;
   logic          last;
   logic          bad;

   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [W-1:0]  sum_sh;
   logic [W-1:0]  sum_next;
   logic          c;
   logic [CW-1:0] cnt;

   logic [3:0]    ds;
   logic          dc;

   logic [W-1:0]  sum_q;
   logic          cout_q;
   logic          err_q;

   bcd_digit_add u_digit (
      .a  (a_sh[3:0]),
      .b  (b_sh[3:0]),
      .ci (c),
      .s  (ds),
      .co (dc)
   );

   // new digit enters at the top so that after NDIG shifts digit 0 sits at the bottom
   generate
      if (NDIG == 1) begin : g_one
         assign sum_next = ds;
      end else begin : g_many
         assign sum_next = {ds, sum_sh[W-1:4]};
      end
   endgenerate

   // any operand nibble above 9 flags the whole operation
   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (!is_bcd(bus.a[4*i +: 4]) || !is_bcd(bus.b[4*i +: 4])) begin
            bad = 1'b1;
         end
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state decode; start is only looked at in IDLE
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      last    = (cnt == CNT_LAST);
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = ADD;
            end
         end
         ADD: begin
            if (last) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // operand shifters, digit carry, counter and held result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         c      <= 1'b0;
         cnt    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (accept) begin
         a_sh  <= bus.a;
         b_sh  <= bus.b;
         c     <= bus.cin;
         cnt   <= '0;
         err_q <= bad;
      end else if (state_q == ADD) begin
         sum_sh <= sum_next;
         a_sh   <= a_sh >> 4;
         b_sh   <= b_sh >> 4;
         c      <= dc;
         cnt    <= cnt + 1'b1;
         // result is captured on the edge into DONE so it is valid alongside done
         if (last) begin
            sum_q  <= sum_next;
            cout_q <= dc;
         end
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = (state_q == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for the digit-serial BCD adder, NDIG=4.
module tb_bcd_serial_adder;

   localparam int NDIG = 4;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   bcd_serial_adder_if #(.NDIG(NDIG)) bus ();

   bcd_serial_adder #(.NDIG(NDIG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // launch one operation and wait (bounded) for done; lat = edges after the accept edge
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         output int lat, output logic ok);
      @(posedge clk); #1;
      bus.a = a; bus.b = b; bus.cin = ci; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 0;
      ok  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h exp=0000", bus.sum); end
      checks++; if (bus.cout !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL reset_flags cout=%b err=%b exp=0/0", bus.cout, bus.err); end
      #3 rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat; logic ok;
      run_op(16'h1234, 16'h5678, 1'b0, lat, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout got=no done exp=done"); end
      checks++; if (lat != NDIG) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, NDIG); end
      checks++; if (bus.sum !== 16'h6912) begin errors++; $display("FAIL basic_sum got=%h exp=6912", bus.sum); end
      checks++; if (bus.cout !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL basic_flags cout=%b err=%b exp=0/0", bus.cout, bus.err); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_pulse done=%b busy=%b exp=0/0", bus.done, bus.busy); end
      checks++; if (bus.sum !== 16'h6912) begin errors++; $display("FAIL basic_hold got=%h exp=6912", bus.sum); end
   endtask

   task automatic test_carry();
      int lat; logic ok;
      run_op(16'h9999, 16'h0001, 1'b0, lat, ok);
      checks++; if (ok !== 1'b1 || bus.sum !== 16'h0000 || bus.cout !== 1'b1) begin errors++; $display("FAIL carry_b ok=%b sum=%h cout=%b exp=1/0000/1", ok, bus.sum, bus.cout); end
      run_op(16'h9999, 16'h0000, 1'b1, lat, ok);
      checks++; if (ok !== 1'b1 || bus.sum !== 16'h0000 || bus.cout !== 1'b1) begin errors++; $display("FAIL carry_cin ok=%b sum=%h cout=%b exp=1/0000/1", ok, bus.sum, bus.cout); end
   endtask

   task automatic test_cin();
      int lat; logic ok;
      run_op(16'h0000, 16'h0000, 1'b1, lat, ok);
      checks++; if (ok !== 1'b1 || bus.sum !== 16'h0001 || bus.cout !== 1'b0) begin errors++; $display("FAIL cin_zero ok=%b sum=%h cout=%b exp=1/0001/0", ok, bus.sum, bus.cout); end
      run_op(16'h9999, 16'h9999, 1'b1, lat, ok);
      checks++; if (ok !== 1'b1 || bus.sum !== 16'h9999 || bus.cout !== 1'b1) begin errors++; $display("FAIL cin_max ok=%b sum=%h cout=%b exp=1/9999/1", ok, bus.sum, bus.cout); end
      run_op(16'h0505, 16'h0505, 1'b0, lat, ok);
      checks++; if (ok !== 1'b1 || bus.sum !== 16'h1010 || bus.cout !== 1'b0) begin errors++; $display("FAIL cin_mid ok=%b sum=%h cout=%b exp=1/1010/0", ok, bus.sum, bus.cout); end
   endtask

   task automatic test_invalid();
      int lat; logic ok;
      run_op(16'h00A0, 16'h0001, 1'b0, lat, ok);
      checks++; if (ok !== 1'b1 || bus.err !== 1'b1) begin errors++; $display("FAIL invalid_err ok=%b err=%b exp=1/1", ok, bus.err); end
      checks++; if (bus.sum !== 16'h0101 || bus.cout !== 1'b0) begin errors++; $display("FAIL invalid_sum sum=%h cout=%b exp=0101/0", bus.sum, bus.cout); end
      run_op(16'h0001, 16'h0001, 1'b0, lat, ok);
      checks++; if (ok !== 1'b1 || bus.err !== 1'b0 || bus.sum !== 16'h0002) begin errors++; $display("FAIL invalid_clear ok=%b err=%b sum=%h exp=1/0/0002", ok, bus.err, bus.sum); end
      run_op(16'h0000, 16'hF000, 1'b0, lat, ok);
      checks++; if (ok !== 1'b1 || bus.err !== 1'b1) begin errors++; $display("FAIL invalid_b_msd ok=%b err=%b exp=1/1", ok, bus.err); end
   endtask

   task automatic test_start_ignored();
      int   lat;
      logic ok;
      logic busy_gap;
      @(posedge clk); #1;
      bus.a = 16'h1234; bus.b = 16'h5678; bus.cin = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      busy_gap = 1'b0;
      ok  = 1'b0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.busy !== 1'b1) busy_gap = 1'b1;
         if (bus.done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         if (i == 1) begin
            bus.a = 16'h9999; bus.b = 16'h9999; bus.cin = 1'b1; bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      bus.start = 1'b0;
      checks++; if (ok !== 1'b1 || lat != NDIG) begin errors++; $display("FAIL ignore_latency ok=%b lat=%0d exp=1/%0d", ok, lat, NDIG); end
      checks++; if (busy_gap !== 1'b0) begin errors++; $display("FAIL ignore_busy got=gap exp=continuous"); end
      checks++; if (bus.sum !== 16'h6912 || bus.cout !== 1'b0) begin errors++; $display("FAIL ignore_sum sum=%h cout=%b exp=6912/0", bus.sum, bus.cout); end
      @(posedge clk); #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_idle busy=%b exp=0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      int   lat;
      int   done_seen;
      logic ok;
      @(posedge clk); #1;
      bus.a = 16'h4444; bus.b = 16'h3333; bus.cin = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.sum !== 16'h0000 || bus.cout !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL midrst_out sum=%h cout=%b err=%b exp=0000/0/0", bus.sum, bus.cout, bus.err); end
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midrst_status busy=%b done=%b exp=0/0", bus.busy, bus.done); end
      #2 rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
      end
      checks++; if (done_seen != 0) begin errors++; $display("FAIL midrst_nodone got=%0d cycles active exp=0", done_seen); end
      run_op(16'h0001, 16'h0001, 1'b0, lat, ok);
      checks++; if (ok !== 1'b1 || bus.sum !== 16'h0002 || lat != NDIG) begin errors++; $display("FAIL midrst_recover ok=%b sum=%h lat=%0d exp=1/0002/%0d", ok, bus.sum, lat, NDIG); end
   endtask

   task automatic test_back_to_back();
      int dones;
      int first_at;
      int second_at;
      logic [15:0] s1;
      logic [15:0] s2;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.a = 16'h0011; bus.b = 16'h0022; bus.cin = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      dones = 0; first_at = -1; second_at = -1; s1 = '0; s2 = '0;
      for (int i = 1; i <= 11; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin
            dones++;
            if (first_at < 0) begin first_at = i; s1 = bus.sum; end
            else begin second_at = i; s2 = bus.sum; end
         end
      end
      bus.start = 1'b0;
      checks++; if (dones != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", dones); end
      checks++; if (first_at != 4 || second_at != 10) begin errors++; $display("FAIL b2b_timing got=%0d,%0d exp=4,10", first_at, second_at); end
      checks++; if (s1 !== 16'h0033 || s2 !== 16'h0033) begin errors++; $display("FAIL b2b_sum got=%h,%h exp=0033,0033", s1, s2); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle busy=%b exp=0", bus.busy); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_basic();
      test_carry();
      test_cin();
      test_invalid();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
